wave_capture_ctrl: RTL and testbench

- Sequences writes into the 512-entry double-buffered waveform RAM that the waveform display reads.
- Arms on a positive-going zero crossing of the audio stream and writes 256 consecutive samples into the half not being displayed.
- Waits for the display to go idle (end of active frame), then flips read_index so the display shows the new capture.
- Sits between the audio sample source and the waveform RAM write port; read_index drives the display's read_index input.

---
 rtl/wave_capture_pkg.sv | 17 +
 rtl/wave_trigger_detect.sv | 28 ++
 rtl/wave_capture_ctrl.sv | 147 ++++++++++++++
 tb/tb_wave_capture_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_capture_pkg.sv
// Shared types and constants for the waveform capture controller.
package wave_capture_pkg;

  // Capture sequencer states; 2'b11 is unused and recovers to ST_ARMED.
  typedef enum logic [1:0] {
    ST_ARMED  = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_WAIT   = 2'b10
  } state_t;

  // Default log2 of samples per RAM half (256 samples per half).
  localparam int HALF_LOG2_DEFAULT = 8;

  // XOR mask turning the top byte of a two's-complement sample into offset binary.
  localparam logic [7:0] OFFSET_BIN_FLIP = 8'h80;

endpackage

// File: rtl/wave_trigger_detect.sv
// Positive-going zero-crossing detector: remembers whether the previous
// accepted sample was negative and flags a sample >= 0 that follows it.
module wave_trigger_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_valid_i,
  input  logic sample_neg_i,
  output logic trigger_o
);

  logic prev_neg_q;
  logic prev_neg_d;

  // Sign of the most recent accepted sample, tracked in every state.
  always_comb begin
    prev_neg_d = prev_neg_q;
    if (sample_valid_i) prev_neg_d = sample_neg_i;
  end

  // prev_neg register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_neg_q <= 1'b0;
    else        prev_neg_q <= prev_neg_d;
  end

  assign trigger_o = sample_valid_i && prev_neg_q && !sample_neg_i;

endmodule

// File: rtl/wave_capture_ctrl.sv
// Waveform capture sequencer for the double-buffered 512-entry waveform RAM.
// Arms on a positive zero crossing, writes 2^HALF_LOG2 samples into the half
// the display is not showing, then flips read_index once the display is idle.
// Optional macro WAVE_CAPTURE_TIMEOUT_EN forces a capture after TIMEOUT
// trigger-less samples while armed.
// Write port: write_en is a one-cycle strobe with write_address/write_sample
// valid in the same cycle; there is no back-pressure, one write per accepted
// sample, issued one clock after sample_valid.
module wave_capture_ctrl
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int HALF_LOG2 = HALF_LOG2_DEFAULT,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [SAMPLE_W-1:0]  sample_in,
  input  logic                 display_idle,
  output logic                 write_en,
  output logic [HALF_LOG2:0]   write_address,
  output logic [7:0]           write_sample,
  output logic                 read_index,
  output state_t               state_dbg
);

  localparam logic [HALF_LOG2-1:0] CNT_ONE  = HALF_LOG2'(1);
  localparam logic [HALF_LOG2-1:0] CNT_LAST = {HALF_LOG2{1'b1}};

  state_t               state_q, state_d;
  logic [HALF_LOG2-1:0] count_q, count_d;
  logic                 read_index_q, read_index_d;
  logic                 write_en_q, write_en_d;
  logic [HALF_LOG2:0]   write_address_q, write_address_d;
  logic [7:0]           write_sample_q, write_sample_d;

  logic                 trigger;
  logic                 timeout_hit;
  logic                 start;
  logic [7:0]           sample_ob;

  wave_trigger_detect u_trig (
    .clk            (clk),
    .rst_n          (reset),
    .sample_valid_i (sample_valid),
    .sample_neg_i   (sample_in[SAMPLE_W-1]),
    .trigger_o      (trigger)
  );

  assign sample_ob = sample_in[SAMPLE_W-1 -: 8] ^ OFFSET_BIN_FLIP;
  assign start     = (state_q == ST_ARMED) && sample_valid && (trigger || timeout_hit);

  if (SAMPLE_W > 8) begin : g_low_bits
    logic unused_low_bits;
    assign unused_low_bits = ^sample_in[SAMPLE_W-9:0];
  end

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

  // Armed-sample counter; held at zero outside ARMED and cleared on capture start.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != ST_ARMED || start) to_cnt_d = '0;
    else if (sample_valid)            to_cnt_d = to_cnt_q + TO_W'(1);
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output decode for the capture sequencer.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    read_index_d    = read_index_q;
    write_en_d      = 1'b0;
    write_address_d = write_address_q;
    write_sample_d  = write_sample_q;
    case (state_q)
      ST_ARMED: begin
        if (start) begin
          write_en_d      = 1'b1;
          write_address_d = {~read_index_q, {HALF_LOG2{1'b0}}};
          write_sample_d  = sample_ob;
          count_d         = CNT_ONE;
          state_d         = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (sample_valid) begin
          write_en_d      = 1'b1;
          write_address_d = {~read_index_q, count_q};
          write_sample_d  = sample_ob;
          count_d         = count_q + CNT_ONE;
          if (count_q == CNT_LAST) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_ARMED;
        count_d = '0;
      end
    endcase
  end

  // Sequencer state and registered write-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_ARMED;
      count_q         <= '0;
      read_index_q    <= 1'b0;
      write_en_q      <= 1'b0;
      write_address_q <= '0;
      write_sample_q  <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      read_index_q    <= read_index_d;
      write_en_q      <= write_en_d;
      write_address_q <= write_address_d;
      write_sample_q  <= write_sample_d;
    end
  end

  assign write_en      = write_en_q;
  assign write_address = write_address_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Self-checking bench for wave_capture_ctrl: a table of directed vectors,
// hand-written multi-cycle sequences and randomized traffic, all compared
// against a capture model kept in terms of "capturing / waiting / shown half".
module tb_wave_capture_ctrl;
  import wave_capture_pkg::*;

  localparam int TIMEOUT = 4096;
  localparam int HALF    = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        display_idle = 1'b0;
  logic        write_en;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        read_index;
  state_t      state_dbg;

  int errors = 0;
  int checks = 0;

  // reference model of the capture behaviour
  bit m_capturing, m_waiting, m_prev_neg;
  int m_n, m_shown, m_armed_cnt;
  bit m_exp_we;
  int m_exp_addr, m_exp_ws;

  typedef struct {
    logic        v;
    logic [15:0] s;
    logic        idle;
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  ws;
    logic        ri;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  wave_capture_ctrl #(.SAMPLE_W(16), .HALF_LOG2(8), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample_in     (sample_in),
    .display_idle  (display_idle),
    .write_en      (write_en),
    .write_address (write_address),
    .write_sample  (write_sample),
    .read_index    (read_index),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_capturing = 0; m_waiting = 0; m_prev_neg = 0;
    m_n = 0; m_shown = 0; m_armed_cnt = 0; m_exp_we = 0;
  endtask

  function automatic int offset_bin(input int sv);
    return ((sv >>> 8) + 128) & 255;
  endfunction

  task automatic model_update(input logic v, input logic [15:0] s, input logic idle);
    int sv;
    bit go;
    sv = int'($signed(s));
    m_exp_we = 0;
    if (m_capturing) begin
      if (v) begin
        m_exp_we = 1;
        m_exp_addr = (1 - m_shown) * HALF + m_n;
        m_exp_ws = offset_bin(sv);
        m_n++;
        if (m_n == HALF) begin
          m_capturing = 0; m_waiting = 1; m_n = 0;
        end
      end
    end else if (m_waiting) begin
      if (idle) begin
        m_shown = 1 - m_shown; m_waiting = 0; m_armed_cnt = 0;
      end
    end else if (v) begin
      go = m_prev_neg && (sv >= 0);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
      if (!go && m_armed_cnt == TIMEOUT - 1) go = 1;
`endif
      if (go) begin
        m_exp_we = 1;
        m_exp_addr = (1 - m_shown) * HALF;
        m_exp_ws = offset_bin(sv);
        m_n = 1; m_capturing = 1; m_armed_cnt = 0;
      end else begin
        m_armed_cnt++;
      end
    end
    if (v) m_prev_neg = (sv < 0);
  endtask

  // one clock: drive inputs, advance model at the edge, compare 1 time unit later
  task automatic step(input logic v, input logic [15:0] s, input logic idle);
    sample_valid = v; sample_in = s; display_idle = idle;
    @(posedge clk);
    model_update(v, s, idle);
    #1;
    check("write_en", int'(write_en), int'(m_exp_we));
    check("read_index", int'(read_index), m_shown);
    if (m_exp_we) begin
      check("write_address", int'(write_address), m_exp_addr);
      check("write_sample", int'(write_sample), m_exp_ws);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; sample_valid = 0; display_idle = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int writes, run, max_run, viol, first_idx;
    // table: reset, -5, +3 triggers, then two more writes with a gap
    vecs[0] = '{1'b1, 16'hFFFB, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 16'h0003, 1'b0, 1'b1, 9'h100, 8'h80, 1'b0};
    vecs[2] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 9'h101, 8'hFF, 1'b0};
    vecs[3] = '{1'b0, 16'h8000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 16'hFF00, 1'b0, 1'b1, 9'h102, 8'h7F, 1'b0};

    do_reset();
    #1;
    check("reset write_en", int'(write_en), 0);
    check("reset write_address", int'(write_address), 0);
    check("reset write_sample", int'(write_sample), 0);
    check("reset read_index", int'(read_index), 0);
    check("reset state", int'(state_dbg), int'(ST_ARMED));

    for (int i = 0; i < 5; i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].idle);
      check($sformatf("vec%0d write_en", i), int'(write_en), int'(vecs[i].we));
      check($sformatf("vec%0d read_index", i), int'(read_index), int'(vecs[i].ri));
      if (vecs[i].we) begin
        check($sformatf("vec%0d addr", i), int'(write_address), int'(vecs[i].addr));
        check($sformatf("vec%0d data", i), int'(write_sample), int'(vecs[i].ws));
      end
    end

    // finish the first capture: 253 more samples up to address 9'h1FF
    for (int i = 0; i < 253; i++) step(1'b1, 16'($urandom), 1'b0);
    check("last addr of capture", int'(write_address), 9'h1FF);
    check("state after capture", int'(state_dbg), int'(ST_WAIT));

    // WAIT with display busy for 1000 cycles, then one idle pulse flips
    writes = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'(($urandom_range(0, 1))), 16'($urandom), 1'b0);
      writes += int'(write_en);
    end
    check("writes while waiting", writes, 0);
    check("read_index before flip", int'(read_index), 0);
    step(1'b0, 16'h0000, 1'b1);
    check("read_index after flip", int'(read_index), 1);
    check("state after flip", int'(state_dbg), int'(ST_ARMED));

    // second capture lands in the lower half
    step(1'b1, 16'hFFFB, 1'b0);
    step(1'b1, 16'h0003, 1'b0);
    check("second capture first addr", int'(write_address), 9'h000);
    for (int i = 0; i < 255; i++) step(1'b1, 16'($urandom), 1'b0);
    check("second capture last addr", int'(write_address), 9'h0FF);
    step(1'b1, 16'h0001, 1'b1);

    // constant positive input
    writes = 0; first_idx = -1;
    for (int i = 1; i <= 10000; i++) begin
      step(1'b1, 16'h4000, 1'b0);
      if (write_en) begin
        if (first_idx < 0) begin
          first_idx = i;
          check("timeout first addr", int'(write_address), 9'h100);
          check("timeout first data", int'(write_sample), 8'hC0);
        end
        writes++;
      end
    end
`ifdef WAVE_CAPTURE_TIMEOUT_EN
    check("timeout capture writes", writes, HALF);
    check("timeout start sample", first_idx, TIMEOUT);
`else
    check("constant input writes", writes, 0);
`endif

    // reset in the middle of a capture
    do_reset();
    step(1'b1, 16'hFFFB, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom_range(0, 16'h7FFF)), 1'b0);
    check("mid write_en before reset", int'(write_en), 1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("mid reset write_en", int'(write_en), 0);
    check("mid reset read_index", int'(read_index), 0);
    check("mid reset state", int'(state_dbg), int'(ST_ARMED));
    @(posedge clk);
    #1 reset = 1'b1;
    writes = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 16'h0001, 1'b0);
      writes += int'(write_en);
    end
    check("writes after reset release", writes, 0);

    // sine input, valid every cycle: one unbroken run of 256 writes
    do_reset();
    writes = 0; run = 0; max_run = 0; viol = 0;
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 16'(int'(20000.0 * $sin(0.3 + 6.2831853 * i / 37.0))), 1'b0);
      if (write_en) begin
        writes++; run++;
        if (write_address[8] == read_index) viol++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("sine total writes", writes, HALF);
    check("sine longest run", max_run, HALF);
    check("sine displayed half written", viol, 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom),
           1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
